// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback path.
//   RegNumWidth / DataWidth : default register index and data widths
//   NUM_REG                 : architectural register count (x0..x31)
//   REQ_ALU/REQ_LSU/REQ_MDU : fixed requester slots on the writeback arbiter
package regfile_wb_arbiter_pkg;

    localparam int RegNumWidth = 5;
    localparam int DataWidth   = 32;
    localparam int NUM_REG     = 32;

    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_MDU = 2;

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// rr_arbiter: purely combinational round-robin arbiter.
//   valid    : per-requester request
//   ptr      : index of the last winner; the scan starts at ptr+1
//   grant    : one-hot grant (zero when nothing is valid)
//   grantIdx : encoded index of the winner (ptr when nothing is valid)
//   anyGrant : some requester won
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PtrW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PtrW-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PtrW-1:0]    grantIdx,
    output logic               anyGrant
);

    localparam logic [PtrW-1:0] LastIdx = PtrW'(NUM_REQ - 1);

    logic [PtrW-1:0] idx;

    // Walk NUM_REQ slots starting one past the last winner. The wrap is
    // explicit so non-power-of-two NUM_REQ never indexes past the end.
    always_comb begin
        grant    = '0;
        grantIdx = ptr;
        anyGrant = 1'b0;
        idx      = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (idx == LastIdx) ? '0 : idx + PtrW'(1);
            if (!anyGrant && valid[idx]) begin
                anyGrant    = 1'b1;
                grant[idx]  = 1'b1;
                grantIdx    = idx;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between NUM_REQ
// writeback units with round-robin arbitration, and keeps a busy-bit
// scoreboard of destinations with writes in flight for hazard detection.
//   clk, reset          : clock, asynchronous active-high reset
//   req_valid/num/data  : packed per-requester write requests (slice k)
//   req_ready           : one-hot grant back to the requesters
//   alloc_valid/num     : issue stage reserving a destination register
//   rd_num0/rd_num1     : source registers of the instruction in issue
//   hazard              : issue must stall (RAW on sources, WAW on alloc)
//   regsWriteEnable/regWriteNum/regWriteData : registered write port
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int RegNumWidth = regfile_wb_arbiter_pkg::RegNumWidth,
    parameter int DataWidth   = regfile_wb_arbiter_pkg::DataWidth
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*RegNumWidth-1:0] req_num,
    input  logic [NUM_REQ*DataWidth-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           alloc_valid,
    input  logic [RegNumWidth-1:0]         alloc_num,
    input  logic [RegNumWidth-1:0]         rd_num0,
    input  logic [RegNumWidth-1:0]         rd_num1,
    output logic                           hazard,
    output logic                           regsWriteEnable,
    output logic [RegNumWidth-1:0]         regWriteNum,
    output logic [DataWidth-1:0]           regWriteData
);

    localparam int PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PtrW-1:0] LastIdx = PtrW'(NUM_REQ - 1);

    logic [PtrW-1:0]        rrPtr;
    logic [PtrW-1:0]        grantIdx;
    logic [NUM_REQ-1:0]     grant;
    logic                   anyGrant;
    logic                   transfer;
    logic [RegNumWidth-1:0] winNum;
    logic [DataWidth-1:0]   winData;
    logic [NUM_REG-1:0]     busy;
    logic [NUM_REG-1:0]     busyNext;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .PtrW(PtrW)) uArb (
        .valid    (req_valid),
        .ptr      (rrPtr),
        .grant    (grant),
        .grantIdx (grantIdx),
        .anyGrant (anyGrant)
    );

    // Grants are masked during reset so nothing is handed out while the
    // state that would record the transfer is being cleared.
    assign req_ready = reset ? '0 : grant;
    assign transfer  = anyGrant & ~reset;

    assign winNum  = req_num[grantIdx*RegNumWidth +: RegNumWidth];
    assign winData = req_data[grantIdx*DataWidth +: DataWidth];

    assign hazard = busy[rd_num0] | busy[rd_num1] | (alloc_valid & busy[alloc_num]);

    // Clear first, then set, so a retiring write and a fresh reservation of
    // the same register leave it busy for the new in-flight write.
    always_comb begin
        busyNext = busy;
        if (transfer && winNum != '0)
            busyNext[winNum] = 1'b0;
        if (alloc_valid && alloc_num != '0)
            busyNext[alloc_num] = 1'b1;
        busyNext[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy            <= '0;
            rrPtr           <= LastIdx;
            regsWriteEnable <= 1'b0;
            regWriteNum     <= '0;
            regWriteData    <= '0;
        end else begin
            busy <= busyNext;
            if (transfer) begin
                rrPtr           <= grantIdx;
                // x0 writes are accepted from the requester but never
                // reach the register file.
                regsWriteEnable <= (winNum != '0);
                regWriteNum     <= winNum;
                regWriteData    <= winData;
            end else begin
                regsWriteEnable <= 1'b0;
            end
        end
    end

endmodule
